// File: rtl/adder_pkg.sv
// adder_pkg: shared widths, op encoding and per-stage payload for pipelined_adder_nbit
`ifndef ADDER_N
`define ADDER_N 32
`endif
`ifndef ADDER_TAG_W
`define ADDER_TAG_W 4
`endif
package adder_pkg;
   localparam int ADDER_N = `ADDER_N;
   localparam int ADDER_TAG_W = `ADDER_TAG_W;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
   function automatic int seg_w(input int n, input int stages);
      return (stages < 1) ? 0 : n / stages;
   endfunction
   typedef struct packed {
      logic [ADDER_N-1:0] a;
      logic [ADDER_N-1:0] b;
      logic [ADDER_N-1:0] sum;
      logic carry;
      logic sub;
      logic [ADDER_TAG_W-1:0] tag;
   } stage_t;
endpackage

// File: rtl/full_adder_nbit.sv
// full_adder_nbit: N-bit ripple adder with carry-in and carry-out
module full_adder_nbit #(
   parameter int N = 8
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_carry,
   output logic [N-1:0] o_sum,
   output logic         o_carry
);
   assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_carry};
endmodule

// File: rtl/pipelined_adder_nbit.sv
// pipelined_adder_nbit: carry-segmented add/sub pipeline with valid/ready; ADDER_FLAGS_EN adds o_zero/o_negative
module pipelined_adder_nbit
   import adder_pkg::*;
#(
   parameter int N = ADDER_N,
   parameter int STAGES = 4,
   parameter int TAG_W = ADDER_TAG_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [N-1:0]     i_a,
   input  logic [N-1:0]     i_b,
   input  logic             i_carry,
   input  logic             i_sub,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [N-1:0]     o_sum,
   output logic             o_carry,
   output logic             o_overflow,
   output logic [TAG_W-1:0] o_tag
`ifdef ADDER_FLAGS_EN
   ,
   output logic             o_zero,
   output logic             o_negative
`endif
);
   localparam int SEG_W = seg_w(N, STAGES);
   if (STAGES < 1 || STAGES > N || N % STAGES != 0 || N != ADDER_N || TAG_W != ADDER_TAG_W) begin : g_bad_cfg
      $error("pipelined_adder_nbit: illegal N/STAGES/TAG_W combination");
   end
   stage_t pipe_q [STAGES];
   stage_t pipe_d [STAGES];
   stage_t src [STAGES];
   logic [STAGES-1:0] v_q, v_d, adv;
   logic [SEG_W-1:0] seg_sum [STAGES];
   logic [STAGES-1:0] seg_co;
   logic unused_last;
   // Payload entering each stage: the new operation for stage 0, the previous register otherwise
   always_comb begin
      src[0] = '0;
      src[0].a = i_a;
      src[0].b = (i_sub == OP_ADD) ? i_b : ~i_b;
      src[0].carry = (i_sub == OP_SUB) ? 1'b1 : i_carry;
      src[0].sub = i_sub;
      src[0].tag = i_tag;
      for (int k = 1; k < STAGES; k++) src[k] = pipe_q[k-1];
   end
   for (genvar g = 0; g < STAGES; g++) begin : g_seg
      full_adder_nbit #(.N(SEG_W)) u_fa (
         .i_a(src[g].a[g*SEG_W +: SEG_W]),
         .i_b(src[g].b[g*SEG_W +: SEG_W]),
         .i_carry(src[g].carry),
         .o_sum(seg_sum[g]),
         .o_carry(seg_co[g])
      );
   end
   // Backpressure chain from the output back to the input, then next state of every stage
   always_comb begin
      adv[STAGES-1] = !v_q[STAGES-1] || i_ready;
      for (int k = STAGES - 2; k >= 0; k--) adv[k] = !v_q[k] || adv[k+1];
      v_d[0] = adv[0] ? i_valid : v_q[0];
      for (int k = 1; k < STAGES; k++) v_d[k] = adv[k] ? v_q[k-1] : v_q[k];
      for (int k = 0; k < STAGES; k++) begin
         pipe_d[k] = adv[k] ? src[k] : pipe_q[k];
         if (adv[k]) begin
            pipe_d[k].sum[k*SEG_W +: SEG_W] = seg_sum[k];
            pipe_d[k].carry = seg_co[k];
         end
      end
   end
   // Stage registers; reset drops everything in flight
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         v_q <= '0;
         for (int k = 0; k < STAGES; k++) pipe_q[k] <= '0;
      end else begin
         v_q <= v_d;
         pipe_q <= pipe_d;
      end
   end
   assign o_ready = adv[0];
   assign o_valid = v_q[STAGES-1];
   assign o_sum = pipe_q[STAGES-1].sum;
   assign o_carry = pipe_q[STAGES-1].carry;
   assign o_tag = pipe_q[STAGES-1].tag;
   assign o_overflow = (pipe_q[STAGES-1].a[N-1] == pipe_q[STAGES-1].b[N-1]) &&
                       (pipe_q[STAGES-1].sum[N-1] != pipe_q[STAGES-1].a[N-1]);
   assign unused_last = ^pipe_q[STAGES-1];
`ifdef ADDER_FLAGS_EN
   logic zero_q, zero_d, negative_q, negative_d;
   // Flags are only raised for a valid result and load with it, so they hold under stall
   always_comb begin
      zero_d = v_d[STAGES-1] && (pipe_d[STAGES-1].sum == '0);
      negative_d = v_d[STAGES-1] && pipe_d[STAGES-1].sum[N-1];
   end
   // Flag registers alongside the final stage
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         zero_q <= 1'b0;
         negative_q <= 1'b0;
      end else begin
         zero_q <= zero_d;
         negative_q <= negative_d;
      end
   end
   assign o_zero = zero_q;
   assign o_negative = negative_q;
`endif
endmodule
